lisnoc_packet_injector: RTL and testbench
=========================================

// Module: lisnoc_packet_injector
// PURPOSE
//  Endpoint transmitter that feeds one router input link, driving link_flit/link_valid/link_ready.
//  Turns a host word stream plus header fields into wormhole packets: HEADER flit, then PAYLOAD flits, then a LAST flit.
//  Sits in the network adapter between the tile and the router's local input port.
//  Whole packet on one VC. Registered output. 1 flit/cycle sustained.
// PARAMETERS
//  FLIT_DATA_WIDTH  32  flit payload bits
//  FLIT_TYPE_WIDTH  2   flit type bits; codes from shared def header (PAYLOAD=00, HEADER=01, LAST=10, SINGLE=11)
//  PH_DEST_WIDTH    5   destination field width, header MSBs
//  PH_PRIO_WIDTH    4   priority field width, directly below dest
//  VCHANNELS        1   virtual channels on the link (>=1)
//  VC_WIDTH         1   width of host_vc, = max(1,clog2(VCHANNELS))
// PORTS
//  clk         in   1                                  clock
//  rst         in   1                                  async reset, active-low
//  host_data   in   FLIT_DATA_WIDTH                    payload word
//  host_last   in   1                                  word is final payload word of packet
//  host_valid  in   1                                  word valid
//  host_ready  out  1                                  word consumed when valid&ready
//  host_dest   in   PH_DEST_WIDTH                      packet destination
//  host_prio   in   PH_PRIO_WIDTH                      packet priority
//  host_vc     in   VC_WIDTH                           VC for packet
//  link_flit   out  FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH    {type,data}
//  link_valid  out  VCHANNELS                          one-hot valid on active VC
//  link_ready  in   VCHANNELS                          per-VC ready from router
//  pkt_count   out  16                                 packets fully sent, wraps
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, link_valid=0, link_flit=0, host_ready=0, pkt_count=0.
//  Output register (OREG): holds link_flit and link_valid.
//   oreg_free = (link_valid==0) | link_ready[cur_vc].
//   OREG loads only when oreg_free. Otherwise flit and valid stay stable.
//   link_ready on non-active VCs is ignored.
//  FSM states IDLE, PAYLOAD:
//   IDLE: host_ready=0.
//    On host_valid & oreg_free: sample host_dest/prio/vc and latch cur_vc.
//    Load HEADER flit: data[W-1 -: PH_DEST_WIDTH]=dest, next PH_PRIO_WIDTH bits=prio, rest 0.
//    link_valid=1<<vc. Go to PAYLOAD. The host word is NOT consumed in IDLE.
//   PAYLOAD: host_ready=oreg_free (combinational).
//    On host_valid & host_ready: load host_data with type LAST if host_last, else PAYLOAD, on cur_vc.
//    After a LAST: go to IDLE and pkt_count+1 when LAST is loaded into OREG.
//    If nothing is loaded and link_ready[cur_vc]: link_valid <- 0 (bubble).
//  Latency: accepted host word appears on link_flit next cycle.
//   Header costs one host-side bubble per packet. Back-to-back packets: next HEADER loads the cycle after LAST is loaded.
//  Every packet has >=1 payload word. SINGLE type is never emitted.
//  host_vc >= VCHANNELS: mapped to VC 0. VCHANNELS=1: host_vc ignored.
//  host_dest/prio/vc are sampled only on the header-load cycle; changes mid-packet are ignored.
//  Simultaneous drain and load: OREG replaced same cycle, no bubble.
//  pkt_count wraps 0xFFFF->0.
//  Reset mid-packet: state cleared, partial worm abandoned (system reset only, no recovery flit).
// STRUCTURE
//  Flit type codes, header field offsets: shared lisnoc def header, not redefined locally.
//  Single module: 2-state FSM + OREG + cur_vc + counter. No sub-module.
// TESTING
//  1 pkt, VC0, dest=5, prio=3, words A,B(last), ready=1 -> HEADER(dest=5,prio=3), PAYLOAD A, LAST B on 3 consecutive cycles; pkt_count=1.
//  VCHANNELS=2, host_vc=1, link_ready=2'b01 -> link_valid=2'b10 held, flit stable, host_ready=0; ready[1]=1 -> advance.
//  Two back-to-back 4-word pkts, ready=1 -> 10 flits in 10 cycles, exactly one host bubble per header.
//  ready toggles 1,0,1,0 during payload -> no flit lost or duplicated; order = host order.
//  host_dest changed mid-packet -> header unchanged, no new header until after LAST.
//  rst=0 asserted mid-packet -> link_valid=0 asynchronously, FSM IDLE, pkt_count=0; next packet starts with HEADER.

Source files
------------

// File: rtl/lisnoc_packet_injector_pkg.sv
// rtl/lisnoc_packet_injector_pkg.sv - shared lisnoc flit definitions and injector state type
package lisnoc_packet_injector_pkg;

  // Flit type codes shared across the lisnoc fabric
  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  // Injector control states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } inj_state_e;

endpackage

// File: rtl/lisnoc_packet_injector.sv
// rtl/lisnoc_packet_injector.sv - host word stream to wormhole packet injector for one router link
module lisnoc_packet_injector
  import lisnoc_packet_injector_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int PH_DEST_WIDTH   = 5,
  parameter int PH_PRIO_WIDTH   = 4,
  parameter int VCHANNELS       = 1,
  parameter int VC_WIDTH        = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [FLIT_DATA_WIDTH-1:0]               host_data,
  input  logic                                     host_last,
  input  logic                                     host_valid,
  output logic                                     host_ready,
  input  logic [PH_DEST_WIDTH-1:0]                 host_dest,
  input  logic [PH_PRIO_WIDTH-1:0]                 host_prio,
  input  logic [VC_WIDTH-1:0]                      host_vc,
  output logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] link_flit,
  output logic [VCHANNELS-1:0]                     link_valid,
  input  logic [VCHANNELS-1:0]                     link_ready,
  output logic [15:0]                              pkt_count
);

  localparam logic [VC_WIDTH:0] VCH_LIMIT = VCHANNELS[VC_WIDTH:0];

  inj_state_e                 state;
  logic [VC_WIDTH-1:0]        cur_vc;
  logic                       oreg_free;
  logic [VC_WIDTH-1:0]        vc_sel;
  logic [VCHANNELS-1:0]       vc_sel_onehot;
  logic [VCHANNELS-1:0]       cur_vc_onehot;
  logic [FLIT_DATA_WIDTH-1:0] hdr_data;

  // The output register may take a new flit when empty or when its flit is being taken on the active VC
  assign oreg_free = ~(|link_valid) | link_ready[cur_vc];

  // Host words are only consumed in PAYLOAD; the header cycle is the per-packet host bubble
  assign host_ready = (state == ST_PAYLOAD) & oreg_free;

  // Out-of-range VC requests fall back to VC 0
  always_comb begin
    vc_sel = '0;
    if ({1'b0, host_vc} < VCH_LIMIT) begin
      vc_sel = host_vc;
    end
  end

  // One-hot valid patterns for the newly requested VC and the VC of the packet in flight
  always_comb begin
    vc_sel_onehot         = '0;
    cur_vc_onehot         = '0;
    vc_sel_onehot[vc_sel] = 1'b1;
    cur_vc_onehot[cur_vc] = 1'b1;
  end

  // Header payload: destination in the MSBs, priority directly below, remaining bits zero
  always_comb begin
    hdr_data = '0;
    hdr_data[FLIT_DATA_WIDTH-1 -: PH_DEST_WIDTH] = host_dest;
    hdr_data[FLIT_DATA_WIDTH-1-PH_DEST_WIDTH -: PH_PRIO_WIDTH] = host_prio;
  end

  // Packet FSM, output register, active VC and sent-packet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_vc     <= '0;
      link_flit  <= '0;
      link_valid <= '0;
      pkt_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_valid && oreg_free) begin
            cur_vc     <= vc_sel;
            link_flit  <= {FLIT_TYPE_WIDTH'(FLIT_TYPE_HEADER), hdr_data};
            link_valid <= vc_sel_onehot;
            state      <= ST_PAYLOAD;
          end else if (oreg_free) begin
            link_valid <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (host_valid && oreg_free) begin
            link_flit  <= {host_last ? FLIT_TYPE_WIDTH'(FLIT_TYPE_LAST)
                                     : FLIT_TYPE_WIDTH'(FLIT_TYPE_PAYLOAD), host_data};
            link_valid <= cur_vc_onehot;
            if (host_last) begin
              state     <= ST_IDLE;
              pkt_count <= pkt_count + 16'd1;
            end
          end else if (oreg_free) begin
            link_valid <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          link_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lisnoc_packet_injector.sv
// tb/tb_lisnoc_packet_injector.sv - directed self-checking bench for lisnoc_packet_injector
module tb_lisnoc_packet_injector;

  logic        clk;
  logic        rst;
  logic [31:0] host_data;
  logic        host_last;
  logic        host_valid;
  logic        host_ready;
  logic [4:0]  host_dest;
  logic [3:0]  host_prio;
  logic [0:0]  host_vc;
  logic [33:0] link_flit;
  logic [1:0]  link_valid;
  logic [1:0]  link_ready;
  logic [15:0] pkt_count;

  int tests;
  int fails;

  lisnoc_packet_injector #(
    .FLIT_DATA_WIDTH(32),
    .FLIT_TYPE_WIDTH(2),
    .PH_DEST_WIDTH(5),
    .PH_PRIO_WIDTH(4),
    .VCHANNELS(2),
    .VC_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_data(host_data),
    .host_last(host_last),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_dest(host_dest),
    .host_prio(host_prio),
    .host_vc(host_vc),
    .link_flit(link_flit),
    .link_valid(link_valid),
    .link_ready(link_ready),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [33:0] exp_seq [10];
  logic [33:0] xfer_q [$];
  logic        acc;
  int          idx;
  int          bubbles;

  initial begin
    tests = 0;
    fails = 0;
    rst        = 1'b0;
    host_data  = '0;
    host_last  = 1'b0;
    host_valid = 1'b0;
    host_dest  = '0;
    host_prio  = '0;
    host_vc    = '0;
    link_ready = 2'b11;
    tick();
    tick();

    // Reset state
    chk("rst_link_valid", 64'(link_valid), 64'h0);
    chk("rst_link_flit",  64'(link_flit),  64'h0);
    chk("rst_host_ready", 64'(host_ready), 64'h0);
    chk("rst_pkt_count",  64'(pkt_count),  64'h0);
    rst = 1'b1;
    tick();

    // One packet on VC0: dest 5, prio 3, words A then B(last)
    host_dest = 5'd5; host_prio = 4'd3; host_vc = 1'b0;
    host_data = 32'hAAAA_0001; host_last = 1'b0; host_valid = 1'b1;
    tick();
    chk("p1_hdr_flit",  64'(link_flit),  64'h1_2980_0000);
    chk("p1_hdr_valid", 64'(link_valid), 64'h1);
    chk("p1_hready",    64'(host_ready), 64'h1);
    tick();
    chk("p1_a_flit", 64'(link_flit), 64'h0_AAAA_0001);
    host_data = 32'hBBBB_0002; host_last = 1'b1;
    tick();
    chk("p1_b_flit",  64'(link_flit),  64'h2_BBBB_0002);
    chk("p1_count",   64'(pkt_count),  64'h1);
    chk("p1_hr_idle", 64'(host_ready), 64'h0);
    host_valid = 1'b0; host_last = 1'b0;
    tick();
    chk("p1_bubble", 64'(link_valid), 64'h0);

    // VC1 stalled by router: only ready[0] high
    link_ready = 2'b01;
    host_dest = 5'd2; host_prio = 4'd1; host_vc = 1'b1;
    host_data = 32'hCCCC_0003; host_valid = 1'b1;
    tick();
    chk("vc1_hdr_valid", 64'(link_valid), 64'h2);
    chk("vc1_hdr_flit",  64'(link_flit),  64'h1_1080_0000);
    chk("vc1_hr_stall",  64'(host_ready), 64'h0);
    tick();
    chk("vc1_hold_valid", 64'(link_valid), 64'h2);
    chk("vc1_hold_flit",  64'(link_flit),  64'h1_1080_0000);
    chk("vc1_hold_hr",    64'(host_ready), 64'h0);
    link_ready = 2'b10;
    #1;
    chk("vc1_hr_go", 64'(host_ready), 64'h1);
    tick();
    chk("vc1_c_flit",  64'(link_flit),  64'h0_CCCC_0003);
    chk("vc1_c_valid", 64'(link_valid), 64'h2);
    host_data = 32'hDDDD_0004; host_last = 1'b1;
    tick();
    chk("vc1_d_flit", 64'(link_flit), 64'h2_DDDD_0004);
    chk("vc1_count",  64'(pkt_count), 64'h2);
    host_valid = 1'b0; host_last = 1'b0;
    tick();
    chk("vc1_bubble", 64'(link_valid), 64'h0);

    // Two back-to-back 4-word packets, ready always high
    link_ready = 2'b11;
    host_dest = 5'd7; host_prio = 4'hF; host_vc = 1'b0;
    exp_seq[0] = 34'h1_3F80_0000;
    exp_seq[1] = 34'h0_1000_0000;
    exp_seq[2] = 34'h0_1000_0001;
    exp_seq[3] = 34'h0_1000_0002;
    exp_seq[4] = 34'h2_1000_0003;
    exp_seq[5] = 34'h1_3F80_0000;
    exp_seq[6] = 34'h0_1000_0004;
    exp_seq[7] = 34'h0_1000_0005;
    exp_seq[8] = 34'h0_1000_0006;
    exp_seq[9] = 34'h2_1000_0007;
    idx = 0; bubbles = 0;
    host_data = 32'h1000_0000; host_last = 1'b0; host_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      acc = host_valid & host_ready;
      if (host_valid && !host_ready) bubbles++;
      tick();
      chk($sformatf("b2b_flit%0d", i), 64'(link_flit), 64'(exp_seq[i]));
      chk($sformatf("b2b_valid%0d", i), 64'(link_valid), 64'h1);
      if (acc) begin
        idx++;
        if (idx < 8) begin
          host_data = 32'h1000_0000 + 32'(idx);
          host_last = (idx == 3) || (idx == 7);
        end else begin
          host_valid = 1'b0;
          host_last  = 1'b0;
        end
      end
    end
    chk("b2b_bubbles", 64'(bubbles), 64'd2);
    chk("b2b_count",   64'(pkt_count), 64'd4);
    tick();

    // Ready toggling during the packet, destination changed mid-packet
    host_dest = 5'd1; host_prio = 4'd2; host_vc = 1'b0;
    idx = 0;
    host_data = 32'hE000_0000; host_last = 1'b0; host_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      link_ready = (i % 2 == 0) ? 2'b11 : 2'b00;
      #1;
      acc = host_valid & host_ready;
      if (link_valid[0] && link_ready[0]) xfer_q.push_back(link_flit);
      tick();
      if (acc) begin
        idx++;
        host_dest = 5'h1F;
        if (idx < 4) begin
          host_data = 32'hE000_0000 + 32'(idx);
          host_last = (idx == 3);
        end else begin
          host_valid = 1'b0;
          host_last  = 1'b0;
        end
      end
    end
    chk("tog_xfers", 64'(xfer_q.size()), 64'd5);
    if (xfer_q.size() == 5) begin
      chk("tog_x0", 64'(xfer_q[0]), 64'h1_0900_0000);
      chk("tog_x1", 64'(xfer_q[1]), 64'h0_E000_0000);
      chk("tog_x2", 64'(xfer_q[2]), 64'h0_E000_0001);
      chk("tog_x3", 64'(xfer_q[3]), 64'h0_E000_0002);
      chk("tog_x4", 64'(xfer_q[4]), 64'h2_E000_0003);
    end
    chk("tog_count", 64'(pkt_count), 64'd5);
    chk("tog_idle_valid", 64'(link_valid), 64'h0);

    // Reset asserted mid-packet
    link_ready = 2'b11;
    host_dest = 5'd3; host_prio = 4'd0; host_vc = 1'b0;
    host_data = 32'hF000_0000; host_last = 1'b0; host_valid = 1'b1;
    tick();
    chk("mid_hdr", 64'(link_flit), 64'h1_1800_0000);
    tick();
    chk("mid_f0", 64'(link_flit), 64'h0_F000_0000);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(link_valid), 64'h0);
    chk("mid_rst_count", 64'(pkt_count),  64'h0);
    chk("mid_rst_hr",    64'(host_ready), 64'h0);
    #2;
    rst = 1'b1;
    host_data = 32'hF000_0001; host_last = 1'b1;
    tick();
    chk("post_rst_hdr",   64'(link_flit),  64'h1_1800_0000);
    chk("post_rst_valid", 64'(link_valid), 64'h1);
    tick();
    chk("post_rst_last",  64'(link_flit), 64'h2_F000_0001);
    chk("post_rst_count", 64'(pkt_count), 64'h1);
    host_valid = 1'b0; host_last = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
